traffic_light_monitor: RTL and testbench

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

---
 rtl/traffic_light_monitor.sv | 197 +++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// traffic_light_monitor
//
// Watches the lamp outputs of a two-way (north-south / east-west) traffic light
// controller. It locks onto the light sequence, tracks the current phase, how
// long that phase has lasted and how many legal phase changes have occurred.
// On the first illegal observation it latches a sticky error with a cause code.
//
// Optional feature (compile-time macro):
//   TRAFFIC_LIGHT_MONITOR_DWELL_CHECK_EN
//     defined   : leaving a green phase before MIN_GREEN cycles, or a yellow
//                 phase before MIN_YELLOW cycles, is a short-dwell error (4).
//     undefined : no dwell checking; error code 4 never occurs.
//
// Ports:
//   i_clk        in   1   clock, rising edge
//   i_reset      in   1   asynchronous active-high reset
//   i_ns_light   in   3   north-south lamps {red,yellow,green}
//   i_ew_light   in   3   east-west lamps {red,yellow,green}
//   i_clr_err    in   1   synchronous clear of the error, forces re-sync
//   o_phase      out  2   0=NS_GREEN 1=NS_YELLOW 2=EW_GREEN 3=EW_YELLOW
//   o_locked     out  1   high while tracking the sequence
//   o_err        out  1   sticky error flag
//   o_err_code   out  3   1=conflict 2=encoding 3=sequence 4=short dwell
//   o_dwell      out  8   cycles spent in the current phase, saturating
//   o_trans_cnt  out  16  legal phase transitions, wrapping
// -----------------------------------------------------------------------------
module traffic_light_monitor #(
    parameter int unsigned MIN_GREEN  = 8,
    parameter int unsigned MIN_YELLOW = 3
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [2:0]  i_ns_light,
    input  logic [2:0]  i_ew_light,
    input  logic        i_clr_err,
    output logic [1:0]  o_phase,
    output logic        o_locked,
    output logic        o_err,
    output logic [2:0]  o_err_code,
    output logic [7:0]  o_dwell,
    output logic [15:0] o_trans_cnt
);

`ifdef TRAFFIC_LIGHT_MONITOR_DWELL_CHECK_EN
    localparam bit DWELL_CHECK_EN = 1'b1;
`else
    localparam bit DWELL_CHECK_EN = 1'b0;
`endif

    localparam logic [2:0] LAMP_RED     = 3'b100;
    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_CONFLICT = 3'd1;
    localparam logic [2:0] ERR_ENCODING = 3'd2;
    localparam logic [2:0] ERR_SEQUENCE = 3'd3;
    localparam logic [2:0] ERR_DWELL    = 3'd4;
    localparam logic [7:0] MIN_GREEN_W  = 8'(MIN_GREEN);
    localparam logic [7:0] MIN_YELLOW_W = 8'(MIN_YELLOW);

    typedef enum logic [1:0] {
        ST_UNSYNC = 2'd0,
        ST_TRACK  = 2'd1,
        ST_FAULT  = 2'd2
    } state_t;

    state_t      r_state,     w_state_next;
    logic [1:0]  r_phase,     w_phase_next;
    logic        r_locked,    w_locked_next;
    logic        r_err,       w_err_next;
    logic [2:0]  r_err_code,  w_err_code_next;
    logic [7:0]  r_dwell,     w_dwell_next;
    logic [15:0] r_trans_cnt, w_trans_cnt_next;
    // Set while still in the phase we synced into; its start time is unknown,
    // so its dwell cannot be judged.
    logic        r_first,     w_first_next;

    logic        w_legal;
    logic [1:0]  w_word_phase;
    logic        w_conflict;
    logic [1:0]  w_phase_succ;
    logic [7:0]  w_min_dwell;
    logic        w_short;
    logic [2:0]  w_viol_code;

    // Lamp word decode
    always_comb begin
        w_legal      = 1'b1;
        w_word_phase = 2'd0;
        case ({i_ns_light, i_ew_light})
            6'b001_100: w_word_phase = 2'd0;
            6'b010_100: w_word_phase = 2'd1;
            6'b100_001: w_word_phase = 2'd2;
            6'b100_010: w_word_phase = 2'd3;
            default:    w_legal      = 1'b0;
        endcase
    end

    assign w_conflict   = (i_ns_light != LAMP_RED) && (i_ew_light != LAMP_RED);
    assign w_phase_succ = r_phase + 2'd1;
    // Odd phases are yellow, even phases are green.
    assign w_min_dwell  = r_phase[0] ? MIN_YELLOW_W : MIN_GREEN_W;
    assign w_short      = DWELL_CHECK_EN && !r_first && (r_dwell < w_min_dwell);

    // Violation classification in priority order; only meaningful in TRACK.
    always_comb begin
        w_viol_code = ERR_NONE;
        if (w_conflict)
            w_viol_code = ERR_CONFLICT;
        else if (!w_legal)
            w_viol_code = ERR_ENCODING;
        else if ((w_word_phase != r_phase) && (w_word_phase != w_phase_succ))
            w_viol_code = ERR_SEQUENCE;
        else if ((w_word_phase == w_phase_succ) && w_short)
            w_viol_code = ERR_DWELL;
    end

    // Next-state and output logic
    always_comb begin
        w_state_next     = r_state;
        w_phase_next     = r_phase;
        w_err_next       = r_err;
        w_err_code_next  = r_err_code;
        w_dwell_next     = r_dwell;
        w_trans_cnt_next = r_trans_cnt;
        w_first_next     = r_first;

        if (i_clr_err) begin
            // Clearing wins over anything observed this cycle.
            w_state_next    = ST_UNSYNC;
            w_err_next      = 1'b0;
            w_err_code_next = ERR_NONE;
            w_dwell_next    = 8'd0;
        end else begin
            case (r_state)
                ST_UNSYNC: begin
                    if (w_legal) begin
                        w_state_next = ST_TRACK;
                        w_phase_next = w_word_phase;
                        w_dwell_next = 8'd1;
                        w_first_next = 1'b1;
                    end
                end
                ST_TRACK: begin
                    if (w_viol_code != ERR_NONE) begin
                        w_state_next    = ST_FAULT;
                        w_err_next      = 1'b1;
                        w_err_code_next = w_viol_code;
                    end else if (w_word_phase == r_phase) begin
                        if (r_dwell != 8'hFF)
                            w_dwell_next = r_dwell + 8'd1;
                    end else begin
                        w_phase_next     = w_word_phase;
                        w_dwell_next     = 8'd1;
                        w_trans_cnt_next = r_trans_cnt + 16'd1;
                        w_first_next     = 1'b0;
                    end
                end
                ST_FAULT: begin
                    // Everything frozen until clear or reset.
                end
                default: w_state_next = ST_UNSYNC;
            endcase
        end

        w_locked_next = (w_state_next == ST_TRACK);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= ST_UNSYNC;
            r_phase     <= 2'd0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= ERR_NONE;
            r_dwell     <= 8'd0;
            r_trans_cnt <= 16'd0;
            r_first     <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_phase     <= w_phase_next;
            r_locked    <= w_locked_next;
            r_err       <= w_err_next;
            r_err_code  <= w_err_code_next;
            r_dwell     <= w_dwell_next;
            r_trans_cnt <= w_trans_cnt_next;
            r_first     <= w_first_next;
        end
    end

    assign o_phase     = r_phase;
    assign o_locked    = r_locked;
    assign o_err       = r_err;
    assign o_err_code  = r_err_code;
    assign o_dwell     = r_dwell;
    assign o_trans_cnt = r_trans_cnt;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_monitor
//
// Directed scenarios plus a randomized lamp stream, all checked against a
// behavioural model of the monitor rules kept in this file. Expectations for
// the short-dwell scenario follow TRAFFIC_LIGHT_MONITOR_DWELL_CHECK_EN.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_traffic_light_monitor;

    localparam int MIN_GREEN  = 8;
    localparam int MIN_YELLOW = 3;
`ifdef TRAFFIC_LIGHT_MONITOR_DWELL_CHECK_EN
    localparam bit DWELL_EN = 1'b1;
`else
    localparam bit DWELL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic [2:0]  ns  = 3'b100;
    logic [2:0]  ew  = 3'b100;
    logic [1:0]  o_phase;
    logic        o_locked;
    logic        o_err;
    logic [2:0]  o_err_code;
    logic [7:0]  o_dwell;
    logic [15:0] o_trans_cnt;

    traffic_light_monitor #(
        .MIN_GREEN  (MIN_GREEN),
        .MIN_YELLOW (MIN_YELLOW)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_ns_light  (ns),
        .i_ew_light  (ew),
        .i_clr_err   (clr),
        .o_phase     (o_phase),
        .o_locked    (o_locked),
        .o_err       (o_err),
        .o_err_code  (o_err_code),
        .o_dwell     (o_dwell),
        .o_trans_cnt (o_trans_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0=waiting for sync, 1=tracking, 2=faulted
    int m_mode, m_phase, m_dwell, m_trans, m_err, m_code, m_first;

    function automatic logic [5:0] phase_word(input int p);
        case (p)
            0:       return 6'b001_100;
            1:       return 6'b010_100;
            2:       return 6'b100_001;
            default: return 6'b100_010;
        endcase
    endfunction

    function automatic int word_phase(input logic [5:0] w);
        for (int k = 0; k < 4; k++)
            if (phase_word(k) == w) return k;
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_phase = 0; m_dwell = 0; m_trans = 0;
        m_err = 0; m_code = 0; m_first = 0;
    endtask

    task automatic model_step(input logic [2:0] n, input logic [2:0] e, input logic c);
        int p;
        int code;
        int min_d;
        p = word_phase({n, e});
        if (c) begin
            m_mode = 0; m_err = 0; m_code = 0; m_dwell = 0;
            return;
        end
        if (m_mode == 0) begin
            if (p >= 0) begin
                m_mode = 1; m_phase = p; m_dwell = 1; m_first = 1;
            end
        end else if (m_mode == 1) begin
            min_d = (m_phase % 2 == 0) ? MIN_GREEN : MIN_YELLOW;
            code = 0;
            if (n != 3'b100 && e != 3'b100)                 code = 1;
            else if (p < 0)                                 code = 2;
            else if (p != m_phase && p != (m_phase + 1) % 4) code = 3;
            else if (p != m_phase && DWELL_EN && m_first == 0 && m_dwell < min_d) code = 4;
            if (code != 0) begin
                m_mode = 2; m_err = 1; m_code = code;
            end else if (p == m_phase) begin
                if (m_dwell < 255) m_dwell++;
            end else begin
                m_phase = p; m_dwell = 1; m_first = 0;
                m_trans = (m_trans + 1) % 65536;
            end
        end
    endtask

    // Drive one cycle's inputs, let the edge happen, advance the model, then
    // settle to a sampling point 1 ns after the edge.
    task automatic tick(input logic [5:0] w, input logic c);
        {ns, ew} = w;
        clr = c;
        @(posedge clk);
        model_step(w[5:3], w[2:0], c);
        #1;
    endtask

    task automatic hold(input int p, input int n);
        repeat (n) tick(phase_word(p), 1'b0);
    endtask

    task automatic apply_reset();
        {ns, ew} = 6'b100_100;
        clr = 1'b0;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({o_phase, o_locked, o_err, o_err_code, o_dwell, o_trans_cnt} !== 31'd0) begin
            errors++;
            $display("FAIL reset_state got ph=%0d lk=%0b err=%0b code=%0d dw=%0d tc=%0d exp all 0",
                     o_phase, o_locked, o_err, o_err_code, o_dwell, o_trans_cnt);
        end
        $display("test_reset done");
    endtask

    task automatic test_legal_cycle();
        apply_reset();
        hold(0, 1);
        checks++;
        if ({o_locked, o_phase, o_dwell} !== {1'b1, 2'd0, 8'd1}) begin
            errors++;
            $display("FAIL sync_latency got lk=%0b ph=%0d dw=%0d exp 1 0 1", o_locked, o_phase, o_dwell);
        end
        hold(0, 9); hold(1, 3); hold(2, 10); hold(3, 3); hold(0, 1);
        checks++;
        if ({o_locked, o_err, o_trans_cnt, o_phase, o_dwell} !== {1'b1, 1'b0, 16'd4, 2'd0, 8'd1}) begin
            errors++;
            $display("FAIL legal_cycle got lk=%0b err=%0b tc=%0d ph=%0d dw=%0d exp 1 0 4 0 1",
                     o_locked, o_err, o_trans_cnt, o_phase, o_dwell);
        end
        $display("test_legal_cycle done");
    endtask

    task automatic test_conflict();
        // Continues from the tracked NS_GREEN state left by test_legal_cycle.
        tick(6'b001_001, 1'b0);
        checks++;
        if ({o_err, o_err_code, o_locked, o_phase, o_trans_cnt} !== {1'b1, 3'd1, 1'b0, 2'd0, 16'd4}) begin
            errors++;
            $display("FAIL conflict got err=%0b code=%0d lk=%0b ph=%0d tc=%0d exp 1 1 0 0 4",
                     o_err, o_err_code, o_locked, o_phase, o_trans_cnt);
        end
        hold(1, 3);
        checks++;
        if ({o_err_code, o_phase, o_dwell, o_trans_cnt} !== {3'd1, 2'd0, 8'd1, 16'd4}) begin
            errors++;
            $display("FAIL fault_frozen got code=%0d ph=%0d dw=%0d tc=%0d exp 1 0 1 4",
                     o_err_code, o_phase, o_dwell, o_trans_cnt);
        end
        $display("test_conflict done");
    endtask

    task automatic test_sequence_clr();
        apply_reset();
        hold(0, 10); hold(1, 3); hold(2, 10); hold(3, 3); hold(0, 10); hold(2, 1);
        checks++;
        if ({o_err, o_err_code, o_locked, o_trans_cnt} !== {1'b1, 3'd3, 1'b0, 16'd4}) begin
            errors++;
            $display("FAIL bad_sequence got err=%0b code=%0d lk=%0b tc=%0d exp 1 3 0 4",
                     o_err, o_err_code, o_locked, o_trans_cnt);
        end
        tick(phase_word(2), 1'b1);
        checks++;
        if ({o_err, o_err_code, o_locked, o_dwell, o_trans_cnt} !== {1'b0, 3'd0, 1'b0, 8'd0, 16'd4}) begin
            errors++;
            $display("FAIL clr_err got err=%0b code=%0d lk=%0b dw=%0d tc=%0d exp 0 0 0 0 4",
                     o_err, o_err_code, o_locked, o_dwell, o_trans_cnt);
        end
        hold(0, 2);
        tick(6'b001_001, 1'b1);
        checks++;
        if ({o_err, o_locked, o_dwell} !== {1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL clr_priority got err=%0b lk=%0b dw=%0d exp 0 0 0", o_err, o_locked, o_dwell);
        end
        $display("test_sequence_clr done");
    endtask

    task automatic test_dwell();
        apply_reset();
        hold(0, 10); hold(1, 3); hold(2, 10); hold(3, 3); hold(0, 5); hold(1, 1);
        checks++;
        if ({o_err, o_err_code, o_locked, o_trans_cnt} !==
            {DWELL_EN, DWELL_EN ? 3'd4 : 3'd0, !DWELL_EN, DWELL_EN ? 16'd4 : 16'd5}) begin
            errors++;
            $display("FAIL short_dwell got err=%0b code=%0d lk=%0b tc=%0d (dwell check %0b)",
                     o_err, o_err_code, o_locked, o_trans_cnt, DWELL_EN);
        end
        // Exactly-minimum dwells are legal; a short first phase is exempt.
        apply_reset();
        hold(0, 2); hold(1, MIN_YELLOW); hold(2, MIN_GREEN); hold(3, MIN_YELLOW);
        hold(0, MIN_GREEN); hold(1, 1);
        checks++;
        if ({o_err, o_locked, o_trans_cnt} !== {1'b0, 1'b1, 16'd5}) begin
            errors++;
            $display("FAIL min_dwell_ok got err=%0b lk=%0b tc=%0d exp 0 1 5", o_err, o_locked, o_trans_cnt);
        end
        $display("test_dwell done");
    endtask

    task automatic test_encoding();
        apply_reset();
        repeat (3) tick(6'b100_100, 1'b0);
        checks++;
        if ({o_err, o_locked} !== 2'b00) begin
            errors++;
            $display("FAIL unsync_allred got err=%0b lk=%0b exp 0 0", o_err, o_locked);
        end
        hold(0, 2);
        tick(6'b100_100, 1'b0);
        checks++;
        if ({o_err, o_err_code, o_locked} !== {1'b1, 3'd2, 1'b0}) begin
            errors++;
            $display("FAIL track_allred got err=%0b code=%0d lk=%0b exp 1 2 0", o_err, o_err_code, o_locked);
        end
        $display("test_encoding done");
    endtask

    task automatic test_saturation_reset();
        apply_reset();
        hold(2, 254);
        checks++;
        if (o_dwell !== 8'd254) begin
            errors++;
            $display("FAIL dwell_254 got %0d exp 254", o_dwell);
        end
        hold(2, 1);
        checks++;
        if (o_dwell !== 8'd255) begin
            errors++;
            $display("FAIL dwell_255 got %0d exp 255", o_dwell);
        end
        hold(2, 45);
        checks++;
        if ({o_dwell, o_locked, o_phase} !== {8'd255, 1'b1, 2'd2}) begin
            errors++;
            $display("FAIL dwell_sat got dw=%0d lk=%0b ph=%0d exp 255 1 2", o_dwell, o_locked, o_phase);
        end
        // Reset mid-cycle must clear outputs before the next rising edge.
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({o_phase, o_locked, o_err, o_err_code, o_dwell, o_trans_cnt} !== 31'd0) begin
            errors++;
            $display("FAIL async_reset got ph=%0d lk=%0b dw=%0d tc=%0d exp all 0",
                     o_phase, o_locked, o_dwell, o_trans_cnt);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        hold(3, 1);
        checks++;
        if ({o_locked, o_phase, o_dwell, o_trans_cnt} !== {1'b1, 2'd3, 8'd1, 16'd0}) begin
            errors++;
            $display("FAIL resync got lk=%0b ph=%0d dw=%0d tc=%0d exp 1 3 1 0",
                     o_locked, o_phase, o_dwell, o_trans_cnt);
        end
        $display("test_saturation_reset done");
    endtask

    task automatic test_random();
        int ip;
        int r;
        logic [5:0] w;
        logic c;
        logic [30:0] exp_v;
        apply_reset();
        ip = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r = $urandom_range(0, 99);
            c = 1'b0;
            if (r < 75) begin
                if ($urandom_range(0, 5) == 0) ip = (ip + 1) % 4;
                w = phase_word(ip);
            end else if (r < 85) begin
                w = phase_word($urandom_range(0, 3));
            end else if (r < 95) begin
                w = 6'($urandom_range(0, 63));
            end else begin
                w = phase_word(ip);
                c = 1'b1;
            end
            tick(w, c);
            exp_v = {2'(m_phase), (m_mode == 1), 1'(m_err), 3'(m_code), 8'(m_dwell), 16'(m_trans)};
            checks++;
            if ({o_phase, o_locked, o_err, o_err_code, o_dwell, o_trans_cnt} !== exp_v) begin
                errors++;
                $display("FAIL random cyc=%0d got ph=%0d lk=%0b err=%0b code=%0d dw=%0d tc=%0d exp ph=%0d lk=%0b err=%0b code=%0d dw=%0d tc=%0d",
                         cyc, o_phase, o_locked, o_err, o_err_code, o_dwell, o_trans_cnt,
                         m_phase, (m_mode == 1), m_err, m_code, m_dwell, m_trans);
            end
        end
        $display("test_random done");
    endtask

    initial begin
        model_reset();
        test_reset();
        test_legal_cycle();
        test_conflict();
        test_sequence_clr();
        test_dwell();
        test_encoding();
        test_saturation_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
